// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 types: arbiter grant state and last-grant encoding.
package bexkat1_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INS  = 2'd1,
    ARB_DAT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_INS = 1'b0,
    GRANT_DAT = 1'b1
  } grant_t;

  localparam int COUNT_W = 4;

endpackage

// File: rtl/bus_arb2.sv
// Two-master pipelined Wishbone arbiter (instruction/data) with a registered
// grant and a per-grant cap on outstanding, un-acked requests.
module bus_arb2
  import bexkat1_pkg::*;
#(
  parameter int MAX_OUT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ins_adr_i,
  input  logic        ins_cyc_i,
  input  logic        ins_stb_i,
  output logic        ins_stall_o,
  output logic        ins_ack_o,
  output logic [31:0] ins_dat_o,
  input  logic [31:0] dat_adr_i,
  input  logic        dat_cyc_i,
  input  logic        dat_stb_i,
  input  logic        dat_we_i,
  input  logic [3:0]  dat_sel_i,
  input  logic [31:0] dat_dat_i,
  output logic        dat_stall_o,
  output logic        dat_ack_o,
  output logic [31:0] dat_dat_o,
  output logic [31:0] adr_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  input  logic        stall_i,
  input  logic [31:0] dat_i
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_OUT);

  arb_state_t         state_reg, state_next;
  grant_t             last_grant_reg, last_grant_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               full;
  logic               accept;
  logic               ack_ok;

  assign full   = (count_reg == MAX_CNT);
  assign accept = stb_o & ~stall_i;
  // Acks with nothing outstanding are stray and must not reach a master.
  assign ack_ok = ack_i & (count_reg != '0);

  assign ins_dat_o = dat_i;
  assign dat_dat_o = dat_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= GRANT_INS;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    count_next      = count_reg;
    unique case (state_reg)
      ARB_IDLE: begin
        count_next = '0;
        // On a tie the master that did not hold the bus last wins.
        if (dat_cyc_i && (!ins_cyc_i || last_grant_reg == GRANT_INS))
          state_next = ARB_DAT;
        else if (ins_cyc_i)
          state_next = ARB_INS;
      end
      ARB_INS, ARB_DAT: begin
        if ((state_reg == ARB_INS && !ins_cyc_i) ||
            (state_reg == ARB_DAT && !dat_cyc_i)) begin
          state_next      = ARB_IDLE;
          last_grant_next = (state_reg == ARB_INS) ? GRANT_INS : GRANT_DAT;
          count_next      = '0;
        end else if (accept && !ack_ok) begin
          count_next = count_reg + 1'b1;
        end else if (ack_ok && !accept) begin
          count_next = count_reg - 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    adr_o       = '0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    we_o        = 1'b0;
    sel_o       = '0;
    dat_o       = '0;
    ins_stall_o = 1'b1;
    ins_ack_o   = 1'b0;
    dat_stall_o = 1'b1;
    dat_ack_o   = 1'b0;
    unique case (state_reg)
      ARB_INS: begin
        adr_o       = ins_adr_i;
        cyc_o       = ins_cyc_i;
        stb_o       = ins_stb_i & ~full;
        sel_o       = 4'hf;
        ins_stall_o = stall_i | full;
        ins_ack_o   = ack_ok;
      end
      ARB_DAT: begin
        adr_o       = dat_adr_i;
        cyc_o       = dat_cyc_i;
        stb_o       = dat_stb_i & ~full;
        we_o        = dat_we_i;
        sel_o       = dat_sel_i;
        dat_o       = dat_dat_i;
        dat_stall_o = stall_i | full;
        dat_ack_o   = ack_ok;
      end
      default: ;
    endcase
  end

endmodule
